// File: rtl/mod_reducer_pkg.sv
// Shared crypto definitions: default operand widths (common with the multiplier)
// and the reducer state encoding.
package mod_reducer_pkg;

  localparam int DATA_LENGTH_DEF = 32;
  localparam int KEY_LENGTH_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REDUCE = 2'd1,
    ST_DONE   = 2'd2
  } red_state_t;

endpackage

// File: rtl/mod_reducer_if.sv
// Start/done request bus between the multiplier side and the modular reducer.
interface mod_reducer_if
  import mod_reducer_pkg::*;
#(
  parameter int DATA_LENGTH = DATA_LENGTH_DEF,
  parameter int KEY_LENGTH  = KEY_LENGTH_DEF
);

  logic                   start_i;
  logic [DATA_LENGTH-1:0] value_i;
  logic [KEY_LENGTH-1:0]  modulus_i;
  logic [KEY_LENGTH-1:0]  remainder_o;
  logic                   done_o;
  logic                   busy_o;
  logic                   error_o;

  modport master (
    output start_i, value_i, modulus_i,
    input  remainder_o, done_o, busy_o, error_o
  );

  modport slave (
    input  start_i, value_i, modulus_i,
    output remainder_o, done_o, busy_o, error_o
  );

endinterface

// File: rtl/mod_reducer.sv
// Bit-serial restoring modular reducer: value mod modulus, one dividend bit per
// cycle through a single conditional subtractor.
module mod_reducer
  import mod_reducer_pkg::*;
#(
  parameter int DATA_LENGTH = DATA_LENGTH_DEF,
  parameter int KEY_LENGTH  = KEY_LENGTH_DEF
) (
  input  logic          clk_i,
  input  logic          reset_i,
  mod_reducer_if.slave  bus
);

  localparam int CNT_W = (DATA_LENGTH > 1) ? $clog2(DATA_LENGTH) : 1;

  // The partial remainder stays below m, so it never needs its top bit; only
  // the shifted-in trial value t carries KEY_LENGTH+1 bits.
  function automatic logic [KEY_LENGTH-1:0] cond_sub(
    input logic [KEY_LENGTH:0]   t,
    input logic [KEY_LENGTH-1:0] m
  );
    logic [KEY_LENGTH:0] m_ext;
    m_ext = {1'b0, m};
    return KEY_LENGTH'((t >= m_ext) ? (t - m_ext) : t);
  endfunction

  red_state_t             r_state;
  logic [DATA_LENGTH-1:0] r_v;
  logic [KEY_LENGTH-1:0]  r_m;
  logic [KEY_LENGTH-1:0]  r_r;
  logic [CNT_W-1:0]       r_cnt;
  logic [KEY_LENGTH-1:0]  r_rem;
  logic                   r_err;

  logic [KEY_LENGTH:0]    w_t;
  logic [KEY_LENGTH-1:0]  w_r_next;

  assign w_t      = {r_r, r_v[DATA_LENGTH-1]};
  assign w_r_next = cond_sub(w_t, r_m);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state <= ST_IDLE;
      r_v     <= '0;
      r_m     <= '0;
      r_r     <= '0;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.start_i) begin
            if (bus.modulus_i != '0) begin
              r_v     <= bus.value_i;
              r_m     <= bus.modulus_i;
              r_r     <= '0;
              r_cnt   <= CNT_W'(DATA_LENGTH - 1);
              r_err   <= 1'b0;
              r_state <= ST_REDUCE;
            end else begin
              r_err   <= 1'b1;
              r_rem   <= '0;
              r_state <= ST_DONE;
            end
          end
        end
        ST_REDUCE: begin
          r_r <= w_r_next;
          r_v <= r_v << 1;
          if (r_cnt == '0) begin
            r_rem   <= w_r_next;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.remainder_o = r_rem;
  assign bus.error_o     = r_err;
  assign bus.done_o      = (r_state == ST_DONE);
  assign bus.busy_o      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mod_reducer.sv
// Randomised bench for mod_reducer against a remainder-and-latency model built
// on the % operator, plus directed literal cases.
module tb_mod_reducer;
  import mod_reducer_pkg::*;

  localparam int DL  = 32;
  localparam int KL  = 16;
  localparam int LIM = 60;

  logic clk_i   = 1'b0;
  logic reset_i = 1'b1;

  mod_reducer_if #(.DATA_LENGTH(DL), .KEY_LENGTH(KL)) bif ();

  mod_reducer #(.DATA_LENGTH(DL), .KEY_LENGTH(KL)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bif.slave)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: a request occupies DL cycles, then a one-cycle result whose
  // remainder is simply value % modulus; zero modulus answers immediately.
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic        m_err  = 1'b0;
  logic [15:0] m_rem  = '0;
  logic [31:0] m_v    = '0;
  logic [15:0] m_m    = '0;

  always @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_err  <= 1'b0;
      m_rem  <= '0;
      m_v    <= '0;
      m_m    <= '0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1'b1;
        m_rem  <= 16'(m_v % {16'd0, m_m});
      end
    end else if (bif.start_i) begin
      if (bif.modulus_i == '0) begin
        m_err  <= 1'b1;
        m_rem  <= '0;
        m_done <= 1'b1;
      end else begin
        m_err  <= 1'b0;
        m_v    <= bif.value_i;
        m_m    <= bif.modulus_i;
        m_left <= DL;
      end
    end
  end

  always @(negedge clk_i) begin
    chk("cyc_done",  {31'd0, bif.done_o},  {31'd0, m_done});
    chk("cyc_busy",  {31'd0, bif.busy_o},  {31'd0, (m_left > 0) || m_done});
    chk("cyc_error", {31'd0, bif.error_o}, {31'd0, m_err});
    chk("cyc_rem",   {16'd0, bif.remainder_o}, {16'd0, m_rem});
  end

  // One request from idle; checks latency, remainder, error and return to idle.
  task automatic do_req(input logic [31:0] v, input logic [15:0] m,
                        input logic [15:0] exp_r, input logic exp_e, input int exp_lat);
    int lat;
    @(negedge clk_i);
    bif.start_i   = 1'b1;
    bif.value_i   = v;
    bif.modulus_i = m;
    @(posedge clk_i);
    #1;
    bif.start_i   = 1'b0;
    bif.value_i   = $urandom;
    bif.modulus_i = 16'($urandom);
    lat = 0;
    while (bif.done_o !== 1'b1 && lat < LIM) begin
      @(posedge clk_i);
      #1;
      lat++;
    end
    chk("latency",   lat, exp_lat);
    chk("remainder", {16'd0, bif.remainder_o}, {16'd0, exp_r});
    chk("error",     {31'd0, bif.error_o}, {31'd0, exp_e});
    @(posedge clk_i);
    #1;
    chk("back_idle", {31'd0, bif.busy_o}, 32'd0);
  endtask

  initial begin
    int nd;
    int k;
    logic [15:0] got;
    logic [31:0] v;
    logic [15:0] m;
    logic [15:0] er;

    bif.start_i   = 1'b0;
    bif.value_i   = '0;
    bif.modulus_i = '0;
    #1 reset_i = 1'b0;
    #1;
    chk("rst_rem",   {16'd0, bif.remainder_o}, 32'd0);
    chk("rst_done",  {31'd0, bif.done_o},  32'd0);
    chk("rst_busy",  {31'd0, bif.busy_o},  32'd0);
    chk("rst_error", {31'd0, bif.error_o}, 32'd0);
    @(negedge clk_i);
    reset_i = 1'b1;

    do_req(32'd1000, 16'd7, 16'd6, 1'b0, DL);
    do_req(32'hFFFF_FFFF, 16'hFFFF, 16'd0, 1'b0, DL);
    do_req(32'd12345, 16'd100, 16'd45, 1'b0, DL);
    do_req(32'd5, 16'd9, 16'd5, 1'b0, DL);
    do_req(32'hDEAD_BEEF, 16'd1, 16'd0, 1'b0, DL);
    do_req(32'd0, 16'd1234, 16'd0, 1'b0, DL);
    do_req(32'h0000_FFFE, 16'hFFFF, 16'hFFFE, 1'b0, DL);
    do_req(32'd777, 16'd0, 16'd0, 1'b1, 0);
    do_req(32'd12345, 16'd100, 16'd45, 1'b0, DL);

    // start_i held high with a changing dividend: exactly one result from the captured value
    @(negedge clk_i);
    bif.start_i   = 1'b1;
    bif.value_i   = 32'd1000;
    bif.modulus_i = 16'd7;
    @(posedge clk_i);
    nd  = 0;
    got = '0;
    repeat (DL + 2) begin
      @(negedge clk_i);
      bif.value_i = $urandom;
      @(posedge clk_i);
      #1;
      if (bif.done_o === 1'b1) begin
        nd++;
        got = bif.remainder_o;
      end
    end
    chk("held_start_dones", nd, 1);
    chk("held_start_rem",   {16'd0, got}, 32'd6);
    @(negedge clk_i);
    bif.start_i = 1'b0;
    k = 0;
    while (bif.busy_o !== 1'b0 && k < 2 * LIM) begin
      @(posedge clk_i);
      #1;
      k++;
    end
    chk("held_start_drain", {31'd0, bif.busy_o}, 32'd0);

    // asynchronous reset in the middle of a reduction
    @(negedge clk_i);
    bif.start_i   = 1'b1;
    bif.value_i   = 32'd1000;
    bif.modulus_i = 16'd7;
    @(posedge clk_i);
    #1 bif.start_i = 1'b0;
    repeat (9) @(posedge clk_i);
    #3 reset_i = 1'b0;
    #1;
    chk("abort_rem",   {16'd0, bif.remainder_o}, 32'd0);
    chk("abort_done",  {31'd0, bif.done_o},  32'd0);
    chk("abort_busy",  {31'd0, bif.busy_o},  32'd0);
    chk("abort_error", {31'd0, bif.error_o}, 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b1;
    nd = 0;
    repeat (DL + 8) begin
      @(posedge clk_i);
      #1;
      if (bif.done_o === 1'b1) nd++;
    end
    chk("abort_no_done", nd, 0);
    do_req(32'd1000, 16'd7, 16'd6, 1'b0, DL);

    for (int i = 0; i < 25; i++) begin
      v = $urandom;
      case ($urandom_range(0, 9))
        0:       m = 16'd0;
        1:       m = 16'd1;
        2:       m = 16'hFFFF;
        default: m = 16'($urandom_range(1, 65535));
      endcase
      er = (m == 16'd0) ? 16'd0 : 16'(v % {16'd0, m});
      do_req(v, m, er, (m == 16'd0), (m == 16'd0) ? 0 : DL);
      repeat ($urandom_range(0, 3)) @(negedge clk_i);
    end

    repeat (2) @(negedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
